adv7393_axi_rd_responder: RTL and testbench

AXI4 read-channel slave that serves read bursts from an internal frame-buffer RAM, the responder end of the AXI master read port driven by the ADV7393 video fetch path. It accepts read-address requests, queues up to two, and returns data beats with per-beat response codes under full R-channel backpressure. A backdoor write port loads pixel data. Used as the frame-buffer endpoint in integration and as the memory model in the ADV7393 bench.

---
 rtl/adv7393_axi_rd_responder_if.sv | 37 +++
 rtl/adv7393_axi_rd_responder.sv | 168 ++++++++++++++++
 tb/tb_adv7393_axi_rd_responder.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/adv7393_axi_rd_responder_if.sv
// AXI4 read-address and read-data channels between the ADV7393 fetch master
// and the frame-buffer responder.
interface adv7393_axi_rd_responder_if #(
  parameter int unsigned DWIDTH = 64,
  parameter int unsigned AWIDTH = 32
);
  logic [AWIDTH-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;
  logic              arlock;
  logic [3:0]        arcache;
  logic [2:0]        arprot;
  logic [3:0]        arregion;
  logic [3:0]        arqos;
  logic              arvalid;
  logic              arready;
  logic [DWIDTH-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;
  logic              rvalid;
  logic              rready;

  modport master (
    output araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, arvalid,
    input  arready,
    input  rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  araddr, arlen, arsize, arburst, arlock, arcache, arprot, arregion, arqos, arvalid,
    output arready,
    output rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/adv7393_axi_rd_responder.sv
// AXI4 read responder serving bursts from a frame-buffer RAM: 2-deep AR queue,
// beat engine, synchronous RAM read and a 2-entry output skid buffer.
module adv7393_axi_rd_responder #(
  parameter int unsigned       DWIDTH    = 64,
  parameter int unsigned       AWIDTH    = 32,
  parameter int unsigned       MEM_WORDS = 4096,
  parameter logic [AWIDTH-1:0] BASE_ADDR = '0
) (
  input  logic                         clk,
  input  logic                         reset,
  adv7393_axi_rd_responder_if.slave    s_axi,
  input  logic                         mem_wr_en,
  input  logic [$clog2(MEM_WORDS)-1:0] mem_wr_addr,
  input  logic [DWIDTH-1:0]            mem_wr_data
);
  localparam int unsigned BYTES     = DWIDTH / 8;
  localparam int unsigned BLOG2     = $clog2(BYTES);
  localparam int unsigned IDXW      = $clog2(MEM_WORDS);
  localparam int unsigned SPAN_LOG2 = IDXW + BLOG2;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
  } ar_req_t;

  typedef struct packed {
    logic [AWIDTH-1:0] addr;
    logic [7:0]        rem;
    logic              fixed;
    logic              slverr;
  } beat_ctx_t;

  typedef struct packed {
    logic [DWIDTH-1:0] data;
    logic [1:0]        resp;
    logic              last;
  } r_beat_t;

  typedef enum logic {IDLE, BURST} state_t;

  logic [DWIDTH-1:0] mem [MEM_WORDS];
  ar_req_t   q_mem [2];
  ar_req_t   head;
  logic      q_wr_ptr, q_rd_ptr, push, pop, q_nonempty, arready_q;
  logic [1:0] q_count, q_count_next;
  state_t    state, state_next;
  beat_ctx_t eng, eng_next, head_ctx, cur, cur_adv;
  logic      cur_last, issue, in_range, rpop, rvalid_q;
  r_beat_t   new_beat, slot0, slot1;
  logic [1:0] out_count, out_count_next;
  logic      unused_ok;

  // Backdoor pixel load; a same-cycle read sees the old word.
  always_ff @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_wr_data;
  end

  assign push         = s_axi.arvalid && arready_q;
  assign q_nonempty   = (q_count != 2'd0);
  assign q_count_next = q_count + 2'(push) - 2'(pop);
  assign head         = q_mem[q_rd_ptr];

  always_ff @(posedge clk) begin
    if (push) q_mem[q_wr_ptr] <= '{s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst};
  end

  // arready looks at occupancy before this cycle's pop, so it never overfills.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_wr_ptr  <= 1'b0;
      q_rd_ptr  <= 1'b0;
      q_count   <= '0;
      arready_q <= 1'b0;
    end else begin
      if (push) q_wr_ptr <= !q_wr_ptr;
      if (pop)  q_rd_ptr <= !q_rd_ptr;
      q_count   <= q_count_next;
      arready_q <= ((q_count + 2'(push)) != 2'd2);
    end
  end

  always_comb begin
    head_ctx.addr   = {head.addr[AWIDTH-1:BLOG2], BLOG2'(0)};
    head_ctx.rem    = head.len;
    head_ctx.fixed  = (head.burst == 2'b00);
    head_ctx.slverr = (head.size != 3'(BLOG2)) || head.burst[1];
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (issue) begin
      if (!cur_last)                                 state_next = BURST;
      else if ((state == BURST) && !q_nonempty)      state_next = IDLE;
    end
  end

  // IDLE issues beat 0 straight from the queue head to meet the T+2 latency.
  always_comb begin
    cur        = (state == BURST) ? eng : head_ctx;
    cur_last   = (cur.rem == 8'd0);
    cur_adv    = cur;
    cur_adv.rem = cur.rem - 8'd1;
    if (!cur.fixed) cur_adv.addr = cur.addr + AWIDTH'(BYTES);
    issue      = ((state == BURST) || q_nonempty) && (out_count != 2'd2);
    pop        = issue && ((state == IDLE) || (cur_last && q_nonempty));
    eng_next   = eng;
    if (issue) eng_next = ((state == BURST) && cur_last) ? head_ctx : cur_adv;
  end

  always_ff @(posedge clk) begin
    if (reset) eng <= '0;
    else       eng <= eng_next;
  end

  always_comb begin
    in_range      = (cur.addr[AWIDTH-1:SPAN_LOG2] == BASE_ADDR[AWIDTH-1:SPAN_LOG2]);
    new_beat.last = cur_last;
    new_beat.data = '0;
    if (cur.slverr) begin
      new_beat.resp = 2'b10;
    end else if (!in_range) begin
      new_beat.resp = 2'b11;
    end else begin
      new_beat.resp = 2'b00;
      new_beat.data = mem[cur.addr[SPAN_LOG2-1:BLOG2]];
    end
  end

  assign rpop           = rvalid_q && s_axi.rready;
  assign out_count_next = out_count + 2'(issue) - 2'(rpop);

  // slot0 drives the R channel; slot1 absorbs the beat in flight during a stall.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_count <= '0;
      rvalid_q  <= 1'b0;
      slot0     <= '0;
      slot1     <= '0;
    end else begin
      out_count <= out_count_next;
      rvalid_q  <= (out_count_next != 2'd0);
      if (rpop) begin
        if (out_count == 2'd2) slot0 <= slot1;
        else if (issue)        slot0 <= new_beat;
        else                   slot0 <= '0;
      end else if (issue) begin
        if (out_count == 2'd0) slot0 <= new_beat;
        else                   slot1 <= new_beat;
      end
    end
  end

  assign s_axi.arready = arready_q;
  assign s_axi.rvalid  = rvalid_q;
  assign s_axi.rdata   = slot0.data;
  assign s_axi.rresp   = slot0.resp;
  assign s_axi.rlast   = slot0.last;

  assign unused_ok = ^{s_axi.arlock, s_axi.arcache, s_axi.arprot, s_axi.arregion,
                       s_axi.arqos, head.addr[BLOG2-1:0]};
endmodule

// File: tb/tb_adv7393_axi_rd_responder.sv
// Directed bench for adv7393_axi_rd_responder: OKAY/DECERR/SLVERR bursts,
// backpressure, back-to-back queueing and reset mid-burst.
module tb_adv7393_axi_rd_responder;
  logic        clk = 1'b0;
  logic        reset;
  logic        mem_wr_en;
  logic [11:0] mem_wr_addr;
  logic [63:0] mem_wr_data;

  int pass_cnt = 0;
  int check_cnt = 0;

  logic [63:0] got_data [16];
  logic [1:0]  got_resp [16];
  logic        got_last [16];
  int          got_n, first_cyc, stall_bad, extra;

  adv7393_axi_rd_responder_if #(.DWIDTH(64), .AWIDTH(32)) bus ();

  adv7393_axi_rd_responder #(
    .DWIDTH(64), .AWIDTH(32), .MEM_WORDS(4096), .BASE_ADDR(32'h0000_0000)
  ) dut (
    .clk(clk), .reset(reset), .s_axi(bus),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] pix(input int i);
    return 64'hA5A5_0000_0000_0000 + 64'(i);
  endfunction

  task automatic load_mem();
    for (int i = 0; i < 66; i++) begin
      mem_wr_en   = 1'b1;
      mem_wr_addr = (i < 64) ? 12'(i) : 12'(4030 + i);
      mem_wr_data = pix((i < 64) ? i : 4030 + i);
      @(posedge clk); #1;
    end
    mem_wr_en = 1'b0;
  endtask

  // Issue one AR, then collect beats using rready pattern rpat; c=1 is the cycle after the AR handshake.
  task automatic run_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [31:0] rpat, input int nbeats);
    int w;
    logic prev_stall;
    logic [63:0] pd;
    logic [1:0] pr;
    logic pl;
    bus.araddr = addr; bus.arlen = len; bus.arsize = size; bus.arburst = burst;
    bus.arvalid = 1'b1; bus.rready = 1'b0;
    w = 0;
    while (bus.arready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    got_n = 0; first_cyc = -1; stall_bad = 0; extra = 0; prev_stall = 1'b0;
    pd = '0; pr = '0; pl = 1'b0;
    for (int c = 1; c <= 100; c++) begin
      if (got_n >= nbeats) break;
      bus.rready = rpat[(c - 1) % 32];
      if (prev_stall && (bus.rvalid !== 1'b1 || bus.rdata !== pd || bus.rresp !== pr || bus.rlast !== pl))
        stall_bad++;
      prev_stall = 1'b0;
      if (bus.rvalid === 1'b1) begin
        if (first_cyc < 0) first_cyc = c;
        if (bus.rready) begin
          got_data[got_n] = bus.rdata; got_resp[got_n] = bus.rresp; got_last[got_n] = bus.rlast;
          got_n++;
        end else begin
          prev_stall = 1'b1; pd = bus.rdata; pr = bus.rresp; pl = bus.rlast;
        end
      end
      @(posedge clk); #1;
    end
    bus.rready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      if (bus.rvalid === 1'b1) extra++;
      @(posedge clk); #1;
    end
    bus.rready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_cnt++; if (bus.arready !== 1'b0) $display("FAIL rst_arready: got %b expected 0", bus.arready); else pass_cnt++;
    check_cnt++; if (bus.rvalid !== 1'b0) $display("FAIL rst_rvalid: got %b expected 0", bus.rvalid); else pass_cnt++;
    check_cnt++; if (bus.rlast !== 1'b0) $display("FAIL rst_rlast: got %b expected 0", bus.rlast); else pass_cnt++;
    check_cnt++; if (bus.rresp !== 2'b00) $display("FAIL rst_rresp: got %b expected 00", bus.rresp); else pass_cnt++;
    check_cnt++; if (bus.rdata !== 64'd0) $display("FAIL rst_rdata: got %h expected 0", bus.rdata); else pass_cnt++;
    reset = 1'b0;
    @(posedge clk); #1;
    check_cnt++; if (bus.arready !== 1'b1) $display("FAIL rst_arready_rise: got %b expected 1", bus.arready); else pass_cnt++;
  endtask

  task automatic test_incr();
    run_read(32'h40, 8'd3, 3'd3, 2'b01, 32'hFFFF_FFFF, 4);
    check_cnt++; if (got_n !== 4) $display("FAIL incr_count: got %0d expected 4", got_n); else pass_cnt++;
    check_cnt++; if (first_cyc !== 2) $display("FAIL incr_latency: got %0d expected 2", first_cyc); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      check_cnt++; if (got_data[i] !== pix(8 + i)) $display("FAIL incr_data[%0d]: got %h expected %h", i, got_data[i], pix(8 + i)); else pass_cnt++;
      check_cnt++; if (got_resp[i] !== 2'b00) $display("FAIL incr_resp[%0d]: got %b expected 00", i, got_resp[i]); else pass_cnt++;
      check_cnt++; if (got_last[i] !== (i == 3)) $display("FAIL incr_last[%0d]: got %b expected %b", i, got_last[i], (i == 3)); else pass_cnt++;
    end
    check_cnt++; if (extra !== 0) $display("FAIL incr_extra: got %0d expected 0", extra); else pass_cnt++;
  endtask

  task automatic test_backpressure();
    run_read(32'h40, 8'd3, 3'd3, 2'b01, 32'h9999_9999, 4);
    check_cnt++; if (got_n !== 4) $display("FAIL bp_count: got %0d expected 4", got_n); else pass_cnt++;
    check_cnt++; if (stall_bad !== 0) $display("FAIL bp_stable: got %0d changes expected 0", stall_bad); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      check_cnt++; if (got_data[i] !== pix(8 + i)) $display("FAIL bp_data[%0d]: got %h expected %h", i, got_data[i], pix(8 + i)); else pass_cnt++;
    end
    check_cnt++; if (got_last[3] !== 1'b1) $display("FAIL bp_last: got %b expected 1", got_last[3]); else pass_cnt++;
    check_cnt++; if (extra !== 0) $display("FAIL bp_extra: got %0d expected 0", extra); else pass_cnt++;
  endtask

  task automatic test_fixed_unaligned();
    run_read(32'h48, 8'd2, 3'd3, 2'b00, 32'hFFFF_FFFF, 3);
    check_cnt++; if (got_n !== 3) $display("FAIL fixed_count: got %0d expected 3", got_n); else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      check_cnt++; if (got_data[i] !== pix(9)) $display("FAIL fixed_data[%0d]: got %h expected %h", i, got_data[i], pix(9)); else pass_cnt++;
    end
    run_read(32'h44, 8'd1, 3'd3, 2'b01, 32'hFFFF_FFFF, 2);
    check_cnt++; if (got_data[0] !== pix(8)) $display("FAIL unal_data0: got %h expected %h", got_data[0], pix(8)); else pass_cnt++;
    check_cnt++; if (got_data[1] !== pix(9)) $display("FAIL unal_data1: got %h expected %h", got_data[1], pix(9)); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic        ov [8];
    logic        oa [8];
    logic [63:0] od [8];
    logic [63:0] exp_d [4];
    int w;
    exp_d[0] = pix(0); exp_d[1] = pix(1); exp_d[2] = pix(32); exp_d[3] = pix(33);
    bus.rready = 1'b1;
    bus.araddr = 32'h0; bus.arlen = 8'd1; bus.arsize = 3'd3; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    w = 0;
    while (bus.arready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    for (int c = 0; c < 8; c++) begin
      ov[c] = bus.rvalid; od[c] = bus.rdata; oa[c] = bus.arready;
      @(posedge clk); #1;
      if (c == 0) bus.araddr = 32'h100;
      if (c == 1) bus.arvalid = 1'b0;
    end
    bus.rready = 1'b0;
    check_cnt++; if (oa[1] !== 1'b1) $display("FAIL b2b_arready_2nd: got %b expected 1", oa[1]); else pass_cnt++;
    check_cnt++; if (oa[2] !== 1'b0) $display("FAIL b2b_arready_full: got %b expected 0", oa[2]); else pass_cnt++;
    check_cnt++; if (oa[3] !== 1'b1) $display("FAIL b2b_arready_back: got %b expected 1", oa[3]); else pass_cnt++;
    check_cnt++; if (ov[1] !== 1'b0) $display("FAIL b2b_early_valid: got %b expected 0", ov[1]); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      check_cnt++; if (ov[2 + i] !== 1'b1) $display("FAIL b2b_valid[%0d]: got %b expected 1", i, ov[2 + i]); else pass_cnt++;
      check_cnt++; if (od[2 + i] !== exp_d[i]) $display("FAIL b2b_data[%0d]: got %h expected %h", i, od[2 + i], exp_d[i]); else pass_cnt++;
    end
    check_cnt++; if (ov[6] !== 1'b0) $display("FAIL b2b_tail_valid: got %b expected 0", ov[6]); else pass_cnt++;
  endtask

  task automatic test_decerr();
    logic [1:0]  er [4];
    logic [63:0] ed [4];
    er[0] = 2'b00; er[1] = 2'b00; er[2] = 2'b11; er[3] = 2'b11;
    ed[0] = pix(4094); ed[1] = pix(4095); ed[2] = 64'd0; ed[3] = 64'd0;
    run_read(32'h0000_7FF0, 8'd3, 3'd3, 2'b01, 32'hFFFF_FFFF, 4);
    check_cnt++; if (got_n !== 4) $display("FAIL dec_count: got %0d expected 4", got_n); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      check_cnt++; if (got_resp[i] !== er[i]) $display("FAIL dec_resp[%0d]: got %b expected %b", i, got_resp[i], er[i]); else pass_cnt++;
      check_cnt++; if (got_data[i] !== ed[i]) $display("FAIL dec_data[%0d]: got %h expected %h", i, got_data[i], ed[i]); else pass_cnt++;
    end
    check_cnt++; if (got_last[3] !== 1'b1) $display("FAIL dec_last: got %b expected 1", got_last[3]); else pass_cnt++;
  endtask

  task automatic test_slverr();
    logic [31:0] ad [3];
    logic [2:0]  sz [3];
    logic [1:0]  bt [3];
    ad[0] = 32'h40;   sz[0] = 3'd2; bt[0] = 2'b01;
    ad[1] = 32'h40;   sz[1] = 3'd3; bt[1] = 2'b10;
    ad[2] = 32'h8000; sz[2] = 3'd2; bt[2] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      run_read(ad[k], 8'd1, sz[k], bt[k], 32'hFFFF_FFFF, 2);
      check_cnt++; if (got_n !== 2) $display("FAIL slv%0d_count: got %0d expected 2", k, got_n); else pass_cnt++;
      for (int i = 0; i < 2; i++) begin
        check_cnt++; if (got_resp[i] !== 2'b10) $display("FAIL slv%0d_resp[%0d]: got %b expected 10", k, i, got_resp[i]); else pass_cnt++;
        check_cnt++; if (got_data[i] !== 64'd0) $display("FAIL slv%0d_data[%0d]: got %h expected 0", k, i, got_data[i]); else pass_cnt++;
      end
      check_cnt++; if (got_last[1] !== 1'b1) $display("FAIL slv%0d_last: got %b expected 1", k, got_last[1]); else pass_cnt++;
    end
  endtask

  task automatic test_reset_midburst();
    int w, beats;
    bus.rready = 1'b1;
    bus.araddr = 32'h0; bus.arlen = 8'd7; bus.arsize = 3'd3; bus.arburst = 2'b01; bus.arvalid = 1'b1;
    w = 0;
    while (bus.arready !== 1'b1 && w < 20) begin @(posedge clk); #1; w++; end
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    @(posedge clk); #1;
    check_cnt++; if (bus.rdata !== pix(0)) $display("FAIL mid_beat0: got %h expected %h", bus.rdata, pix(0)); else pass_cnt++;
    @(posedge clk); #1;
    check_cnt++; if (bus.rdata !== pix(1)) $display("FAIL mid_beat1: got %h expected %h", bus.rdata, pix(1)); else pass_cnt++;
    reset = 1'b1;
    @(posedge clk); #1;
    check_cnt++; if (bus.rvalid !== 1'b0) $display("FAIL mid_rvalid: got %b expected 0", bus.rvalid); else pass_cnt++;
    check_cnt++; if (bus.rdata !== 64'd0) $display("FAIL mid_rdata: got %h expected 0", bus.rdata); else pass_cnt++;
    reset = 1'b0;
    beats = 0;
    for (int c = 0; c < 12; c++) begin
      if (bus.rvalid === 1'b1) beats++;
      @(posedge clk); #1;
    end
    check_cnt++; if (beats !== 0) $display("FAIL mid_no_more: got %0d beats expected 0", beats); else pass_cnt++;
    run_read(32'h40, 8'd1, 3'd3, 2'b01, 32'hFFFF_FFFF, 2);
    check_cnt++; if (got_n !== 2) $display("FAIL mid_fresh_count: got %0d expected 2", got_n); else pass_cnt++;
    check_cnt++; if (got_data[0] !== pix(8)) $display("FAIL mid_fresh_d0: got %h expected %h", got_data[0], pix(8)); else pass_cnt++;
    check_cnt++; if (got_data[1] !== pix(9)) $display("FAIL mid_fresh_d1: got %h expected %h", got_data[1], pix(9)); else pass_cnt++;
    check_cnt++; if (got_last[1] !== 1'b1) $display("FAIL mid_fresh_last: got %b expected 1", got_last[1]); else pass_cnt++;
  endtask

  initial begin
    reset = 1'b1;
    mem_wr_en = 1'b0; mem_wr_addr = '0; mem_wr_data = '0;
    bus.araddr = '0; bus.arlen = '0; bus.arsize = 3'd3; bus.arburst = 2'b01;
    bus.arlock = 1'b0; bus.arcache = '0; bus.arprot = '0; bus.arregion = '0; bus.arqos = '0;
    bus.arvalid = 1'b0; bus.rready = 1'b0;
    test_reset();
    load_mem();
    test_incr();
    test_backpressure();
    test_fixed_unaligned();
    test_back_to_back();
    test_decerr();
    test_slverr();
    test_reset_midburst();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end
endmodule
